// File: rtl/decoder_scan_nm_if.sv
// Bus bundle for decoder_scan_nm: enable, mode, select, scan control in; decoded outputs and status out.
// The slave modport is the decoder side; the master modport is the driver side.
interface decoder_scan_nm_if #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8
);
    logic                  en_n_in;
    logic                  mode_in;
    logic [SEL_W-1:0]      sel_in;
    logic                  start_in;
    logic                  loop_in;
    logic [DWELL_W-1:0]    dwell_in;
    logic [(1<<SEL_W)-1:0] y_out;
    logic [SEL_W-1:0]      idx_out;
    logic                  busy_out;
    logic                  done_out;

    modport slave (
        input  en_n_in, mode_in, sel_in, start_in, loop_in, dwell_in,
        output y_out, idx_out, busy_out, done_out
    );

    modport master (
        output en_n_in, mode_in, sel_in, start_in, loop_in, dwell_in,
        input  y_out, idx_out, busy_out, done_out
    );
endinterface

// File: rtl/decoder_scan_nm.sv
// Registered one-hot decoder with optional scan sequencer (built when DECODER_SCAN_EN is defined).
// Without DECODER_SCAN_EN it is a registered direct decoder; busy/done are tied low.
module decoder_scan_nm #(
    parameter int SEL_W   = 4,
    parameter int DWELL_W = 8,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic                clk_in,
    input  logic                rst_in,
    decoder_scan_nm_if.slave    bus
);
    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] Y_IDLE = {N{ACT_LOW}};

    function automatic logic [N-1:0] f_onehot(input logic [SEL_W-1:0] i);
        f_onehot    = '0;
        f_onehot[i] = 1'b1;
    endfunction

    logic [N-1:0]     r_y;
    logic [SEL_W-1:0] r_idx;
    logic [N-1:0]     w_y_nxt;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_act;

`ifdef DECODER_SCAN_EN
    // state  | meaning
    // S_IDLE | direct decode, or waiting for a scan start
    // S_RUN  | scanning; index advances after Dl+1 cycles each
    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [SEL_W-1:0] IDX_LAST = '1;

    state_t             r_state, w_state_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0] r_dl, w_dl_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_dl    <= '0;
            r_idx   <= '0;
            r_y     <= Y_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dl    <= w_dl_nxt;
            r_idx   <= w_idx_nxt;
            r_y     <= w_y_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dl_nxt    = r_dl;
        w_idx_nxt   = r_idx;
        w_act       = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!bus.en_n_in) begin
                    if (!bus.mode_in) begin
                        w_act     = 1'b1;
                        w_idx_nxt = bus.sel_in;
                    end else if (bus.start_in) begin
                        w_dl_nxt    = bus.dwell_in;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_act       = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (bus.en_n_in) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == r_dl) begin
                    w_cnt_nxt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_done_nxt = 1'b1;
                        if (bus.loop_in) begin
                            w_idx_nxt  = '0;
                            w_act      = 1'b1;
                            w_busy_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_idx_nxt  = r_idx + 1'b1;
                        w_act      = 1'b1;
                        w_busy_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                    w_act      = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // The whole output word comes from one index, so at most one bit is ever active.
        w_y_nxt = Y_IDLE ^ (w_act ? f_onehot(w_idx_nxt) : '0);
    end

    assign bus.busy_out = r_busy;
    assign bus.done_out = r_done;
`else
    logic w_unused_scan;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_idx <= '0;
            r_y   <= Y_IDLE;
        end else begin
            r_idx <= w_idx_nxt;
            r_y   <= w_y_nxt;
        end
    end

    always_comb begin
        w_act     = ~bus.en_n_in;
        w_idx_nxt = bus.en_n_in ? r_idx : bus.sel_in;
        w_y_nxt   = Y_IDLE ^ (w_act ? f_onehot(w_idx_nxt) : '0);
    end

    assign w_unused_scan = ^{bus.mode_in, bus.start_in, bus.loop_in, bus.dwell_in};
    assign bus.busy_out  = 1'b0;
    assign bus.done_out  = 1'b0;
`endif

    assign bus.y_out   = r_y;
    assign bus.idx_out = r_idx;
endmodule

// File: tb/tb_decoder_scan_nm.sv
// Randomised self-checking bench for decoder_scan_nm; follows DECODER_SCAN_EN like the design.
// Two instances (active-high and active-low outputs) share one set of inputs.
module tb_decoder_scan_nm;
    localparam int SEL_W   = 4;
    localparam int DWELL_W = 8;
    localparam int N       = 1 << SEL_W;
`ifdef DECODER_SCAN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk_in = ~clk_in;

    decoder_scan_nm_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus0 ();
    decoder_scan_nm_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus1 ();

    assign bus1.en_n_in  = bus0.en_n_in;
    assign bus1.mode_in  = bus0.mode_in;
    assign bus1.sel_in   = bus0.sel_in;
    assign bus1.start_in = bus0.start_in;
    assign bus1.loop_in  = bus0.loop_in;
    assign bus1.dwell_in = bus0.dwell_in;

    decoder_scan_nm #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACT_LOW(1'b0)) dut0 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus0.slave));
    decoder_scan_nm #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .ACT_LOW(1'b1)) dut1 (
        .clk_in(clk_in), .rst_in(rst_in), .bus(bus1.slave));

    int vectors = 0;
    int errs    = 0;

    // Reference: a scan is a cycle count c since start; index = c/(D+1), sweep ends at c = N*(D+1).
    bit           m_run;
    int           m_c, m_d;
    logic [N-1:0] m_y;
    logic [3:0]   m_idx;
    bit           m_idx_known;
    bit           m_busy, m_done;

    task automatic model_edge();
        m_done = 1'b0;
        if (rst_in) begin
            m_run = 0; m_y = '0; m_idx = '0; m_idx_known = 1; m_busy = 0; m_c = 0;
        end else if (m_run) begin
            if (bus0.en_n_in) begin
                m_run = 0; m_y = '0; m_busy = 0;
            end else begin
                m_c++;
                if (m_c == N * (m_d + 1)) begin
                    m_c = 0;
                    m_done = 1'b1;
                    if (bus0.loop_in) begin
                        m_idx = '0; m_y = N'(1);
                    end else begin
                        m_run = 0; m_y = '0; m_busy = 0; m_idx_known = 0;
                    end
                end else begin
                    m_idx = 4'(m_c / (m_d + 1));
                    m_y   = N'(1) << m_idx;
                end
            end
        end else begin
            if (bus0.en_n_in) begin
                m_y = '0;
            end else if (!SCAN || !bus0.mode_in) begin
                m_idx = bus0.sel_in; m_y = N'(1) << bus0.sel_in; m_idx_known = 1;
            end else if (bus0.start_in) begin
                m_run = 1; m_c = 0; m_d = int'(bus0.dwell_in);
                m_idx = '0; m_idx_known = 1; m_y = N'(1); m_busy = 1;
            end else begin
                m_y = '0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        model_edge();
    endtask

    task automatic drive_idle();
        bus0.en_n_in = 1'b1; bus0.mode_in = 1'b0; bus0.sel_in = '0;
        bus0.start_in = 1'b0; bus0.loop_in = 1'b0; bus0.dwell_in = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_in = 1'b1;
        step(); step();
        vectors++;
        if (bus0.y_out !== 16'h0000 || bus1.y_out !== 16'hFFFF) begin
            errs++; $display("FAIL reset_y: got %h/%h want 0000/ffff", bus0.y_out, bus1.y_out);
        end
        vectors++;
        if (bus0.busy_out !== 1'b0 || bus0.done_out !== 1'b0 || bus0.idx_out !== 4'd0) begin
            errs++; $display("FAIL reset_status: busy %b done %b idx %0d want 0 0 0",
                             bus0.busy_out, bus0.done_out, bus0.idx_out);
        end
        rst_in = 1'b0;
    endtask

    task automatic test_direct();
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b0;
        for (int s = 0; s < N; s++) begin
            bus0.sel_in = 4'(s);
            step();
            vectors++;
            if (bus0.y_out !== m_y || bus1.y_out !== ~m_y || bus0.idx_out !== m_idx) begin
                errs++; $display("FAIL direct sel=%0d: y %h/%h idx %0d want %h/%h idx %0d",
                                 s, bus0.y_out, bus1.y_out, bus0.idx_out, m_y, ~m_y, m_idx);
            end
        end
        bus0.en_n_in = 1'b1;
        step();
        vectors++;
        if (bus0.y_out !== m_y || bus1.y_out !== ~m_y) begin
            errs++; $display("FAIL direct_disable: y %h/%h want %h/%h", bus0.y_out, bus1.y_out, m_y, ~m_y);
        end
    endtask

    task automatic test_single_sweep();
        int dones = 0;
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b1; bus0.dwell_in = 8'd2;
        bus0.loop_in = 1'b0; bus0.sel_in = 4'd7; bus0.start_in = 1'b1;
        step();
        bus0.start_in = 1'b0;
        for (int i = 0; i < 55; i++) begin
            vectors++;
            if (bus0.y_out !== m_y || bus0.busy_out !== m_busy || bus0.done_out !== m_done
                || (m_idx_known && bus0.idx_out !== m_idx)) begin
                errs++; $display("FAIL sweep cyc %0d: y %h busy %b done %b idx %0d want %h %b %b %0d",
                                 i, bus0.y_out, bus0.busy_out, bus0.done_out, bus0.idx_out,
                                 m_y, m_busy, m_done, m_idx);
            end
            if (bus0.done_out === 1'b1) dones++;
            step();
        end
        vectors++;
        if (dones != (SCAN ? 1 : 0) || bus0.busy_out !== 1'b0) begin
            errs++; $display("FAIL sweep_end: done pulses %0d busy %b want %0d 0",
                             dones, bus0.busy_out, SCAN ? 1 : 0);
        end
    endtask

    task automatic test_loop_zero_dwell();
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b1; bus0.dwell_in = 8'd0;
        bus0.loop_in = 1'b1; bus0.start_in = 1'b1;
        step();
        bus0.start_in = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 50) bus0.loop_in = 1'b0;
            vectors++;
            if (bus0.y_out !== m_y || bus1.y_out !== ~m_y || bus0.done_out !== m_done
                || bus0.busy_out !== m_busy || $countones(bus0.y_out) > 1) begin
                errs++; $display("FAIL loop cyc %0d: y %h/%h done %b busy %b want %h/%h %b %b",
                                 i, bus0.y_out, bus1.y_out, bus0.done_out, bus0.busy_out,
                                 m_y, ~m_y, m_done, m_busy);
            end
            step();
        end
    endtask

    task automatic test_abort();
        int budget = 200;
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b1; bus0.loop_in = 1'b1;
        bus0.dwell_in = 8'($urandom_range(0, 3)); bus0.start_in = 1'b1;
        step();
        bus0.start_in = 1'b0;
        while (!(m_run && m_idx == 4'd5) && budget > 0) begin
            step();
            budget--;
        end
        if (SCAN && budget == 0) begin
            vectors++; errs++; $display("FAIL abort_wait: index 5 not reached, budget 0 want >0");
        end
        bus0.en_n_in = 1'b1;
        step();
        vectors++;
        if (bus0.y_out !== m_y || bus0.busy_out !== m_busy || bus0.done_out !== m_done
            || bus1.y_out !== ~m_y) begin
            errs++; $display("FAIL abort: y %h busy %b done %b want %h %b %b",
                             bus0.y_out, bus0.busy_out, bus0.done_out, m_y, m_busy, m_done);
        end
    endtask

    task automatic test_ignored_inputs();
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b1; bus0.loop_in = 1'b0;
        bus0.dwell_in = 8'd1; bus0.start_in = 1'b1;
        step();
        for (int i = 0; i < 40; i++) begin
            bus0.start_in = 1'($urandom_range(0, 1));
            bus0.mode_in  = 1'($urandom_range(0, 1));
            bus0.sel_in   = 4'($urandom);
            bus0.dwell_in = 8'($urandom);
            if (!m_run) begin
                bus0.start_in = 1'b0; bus0.mode_in = 1'b1;
            end
            step();
            vectors++;
            if (bus0.y_out !== m_y || bus0.busy_out !== m_busy || bus0.done_out !== m_done
                || (m_idx_known && bus0.idx_out !== m_idx)) begin
                errs++; $display("FAIL ignored cyc %0d: y %h busy %b done %b idx %0d want %h %b %b %0d",
                                 i, bus0.y_out, bus0.busy_out, bus0.done_out, bus0.idx_out,
                                 m_y, m_busy, m_done, m_idx);
            end
        end
        bus0.start_in = 1'b0;
    endtask

    task automatic test_midscan_reset();
        int budget = 100;
        bus0.en_n_in = 1'b0; bus0.mode_in = 1'b1; bus0.loop_in = 1'b1;
        bus0.dwell_in = 8'd1; bus0.start_in = 1'b1;
        step();
        bus0.start_in = 1'b0;
        while (!(m_run && m_idx == 4'd9) && budget > 0) begin
            step();
            budget--;
        end
        if (SCAN && budget == 0) begin
            vectors++; errs++; $display("FAIL reset_wait: index 9 not reached, budget 0 want >0");
        end
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        vectors++;
        if (bus0.y_out !== 16'h0000 || bus1.y_out !== 16'hFFFF || bus0.busy_out !== 1'b0
            || bus0.done_out !== 1'b0 || bus0.idx_out !== 4'd0) begin
            errs++; $display("FAIL midscan_reset: y %h/%h busy %b done %b idx %0d want 0000/ffff 0 0 0",
                             bus0.y_out, bus1.y_out, bus0.busy_out, bus0.done_out, bus0.idx_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_in        = ($urandom_range(0, 299) == 0);
            bus0.en_n_in  = ($urandom_range(0, 39) == 0);
            bus0.mode_in  = ($urandom_range(0, 3) != 0);
            bus0.sel_in   = 4'($urandom);
            bus0.start_in = ($urandom_range(0, 7) == 0);
            bus0.loop_in  = 1'($urandom_range(0, 1));
            bus0.dwell_in = 8'($urandom_range(0, 3));
            step();
            vectors++;
            if (bus0.y_out !== m_y || bus1.y_out !== ~m_y || bus0.busy_out !== m_busy
                || bus0.done_out !== m_done || (m_idx_known && bus0.idx_out !== m_idx)
                || $countones(bus0.y_out) > 1) begin
                errs++; $display("FAIL random cyc %0d: y %h/%h busy %b done %b idx %0d want %h/%h %b %b %0d",
                                 i, bus0.y_out, bus1.y_out, bus0.busy_out, bus0.done_out,
                                 bus0.idx_out, m_y, ~m_y, m_busy, m_done, m_idx);
            end
        end
        rst_in = 1'b0;
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_direct();
        test_single_sweep();
        test_loop_zero_dwell();
        test_abort();
        test_ignored_inputs();
        test_midscan_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/decoder_scan_nm.md
# decoder_scan_nm

Parametrised registered one-hot decoder: `SEL_W` select bits drive `2**SEL_W` outputs behind an active-low enable, with selectable output polarity. An optional scan sequencer steps the active output through every index with a programmable dwell. Typical uses are row and strobe scanning: LED/keypad matrices, chip-select rotation, and time-slot gating. It is the clocked, parametrised replacement for the fixed 4-to-16 combinational decoders.

## Interface
Parameters:
- `SEL_W`, default 4: select width; output width `N = 2**SEL_W`.
- `DWELL_W`, default 8: width of the dwell counter.
- `ACT_LOW`, default 0: output polarity.
  - 0: the selected output reads 1 and the rest read 0.
  - 1: outputs are inverted, so the selected output reads 0 and inactive outputs read 1.

Ports:
- `clk_in` in 1: the single clock; all logic is on the rising edge.
- `rst_in` in 1: reset, synchronous and active-high.
- `en_n_in` in 1: active-low enable; high forces all outputs inactive and aborts any scan.
- `mode_in` in 1: 0 selects direct decode, 1 selects scan (sampled only in IDLE).
- `sel_in` in `SEL_W`: index for direct mode.
- `start_in` in 1: one-cycle request that starts a scan.
- `loop_in` in 1: 1 means restart at index 0 after each sweep; sampled at every sweep end.
- `dwell_in` in `DWELL_W`: hold count D; each index is held D+1 cycles; latched at start.
- `y_out` out `N`: registered decoded outputs.
- `idx_out` out `SEL_W`: index currently driven.
- `busy_out` out 1: high while a scan is in progress.
- `done_out` out 1: one-cycle pulse at the end of each sweep.

## Operation
"Inactive" means all-0 when `ACT_LOW=0` and all-1 when `ACT_LOW=1`.

Reset values:
- `y_out` inactive.
- `idx_out`, `busy_out` and `done_out` all 0.
- FSM in IDLE; dwell counter 0.

FSM states: IDLE and RUN.
- **IDLE, `en_n_in`=1:** `y_out` inactive; `idx_out` holds.
- **IDLE, `en_n_in`=0, `mode_in`=0 (direct):** `y_out` is registered one-hot of `sel_in`; `idx_out` = `sel_in`. `start_in` is ignored.
- **IDLE, `en_n_in`=0, `mode_in`=1, `start_in`=1:** latch `dwell_in` into Dl; set index 0 and the dwell counter to 0; go to RUN.
- **IDLE, `mode_in`=1, `start_in`=0:** `y_out` inactive.
- **RUN:** `busy_out`=1; `y_out` is one-hot of the current index.
  - Each cycle the dwell counter increments.
  - When the counter equals Dl, it clears and the index increments.
  - Index arithmetic is modulo N.
- **Sweep end** (index N-1 with counter = Dl):
  - `done_out` pulses for 1 cycle.
  - If `loop_in`=1: index goes to 0 and the FSM stays in RUN.
  - Else: the FSM goes to IDLE with `y_out` inactive and `busy_out`=0.
- **Abort:** `en_n_in`=1 in RUN sends the FSM to IDLE; `y_out` is inactive next cycle; `done_out` does not pulse.
- **In RUN, the following are ignored:** `start_in`, `mode_in`, `sel_in` and `dwell_in`.
- **Dl = 0:** the index advances every cycle.
- **Single-hot guarantee:** `y_out` never has more than one active bit in any cycle, including on transitions.

## Timing
- **Direct-mode latency:** 1 cycle from `sel_in`/`en_n_in` to `y_out`.
- **Scan start:** `start_in` is sampled at edge t.
  - At t+1: `busy_out`=1, `idx_out`=0, index 0 active.
- **Sweep length:** index k is active for exactly Dl+1 consecutive cycles. A full sweep is N·(Dl+1) cycles.
- **`done_out` timing:** asserts in the first cycle after the last dwell cycle of index N-1. In that same cycle either `y_out` is inactive with `busy_out`=0, or index 0 is active (loop).
- **Reset priority:** `rst_in` has priority over everything.
  - Reset asserted mid-scan: outputs take reset values at the next edge.
- **Outputs:** all outputs are registered, with no combinational input-to-output path.

## Configuration
- `DECODER_SCAN_EN` defined: the scan FSM, dwell counter and `loop_in` logic are built as described above.
- `DECODER_SCAN_EN` undefined: the block is a registered direct decoder only.
  - `mode_in`, `start_in`, `loop_in` and `dwell_in` are ignored.
  - `busy_out` and `done_out` are tied 0.
  - Direct decode behaves as described whatever `mode_in` is.
- The port list is identical in both builds.

## Test plan
- **Reset value:** `SEL_W`=4, `ACT_LOW`=0; apply reset -> `y_out`=0x0000, `busy_out`=0, `done_out`=0. With `ACT_LOW`=1 -> `y_out`=0xFFFF.
- **Direct decode:** `en_n_in`=0, `mode_in`=0, step `sel_in` 0..15 -> one cycle later `y_out`=1<<`sel_in`. Then `en_n_in`=1 -> `y_out`=0x0000 next cycle.
- **Single sweep:** `mode_in`=1, `dwell_in`=2, `loop_in`=0, pulse `start_in` -> each index held 3 cycles over 48 cycles; `done_out` pulses once; then `y_out`=0 and `busy_out`=0.
- **Loop and zero dwell:** `loop_in`=1, `dwell_in`=0 -> index advances every cycle; `done_out` pulses every 16 cycles, coincident with `y_out`=0x0001. Check at most one hot bit every cycle.
- **Abort and ignored start:** `en_n_in`=1 at index 5 -> next cycle `y_out`=0, `busy_out`=0, no `done_out`. Separately, `start_in` pulsed during RUN -> scan is unaffected.
- **Mid-scan reset and macro-off build:** `rst_in` at index 9 -> reset values next cycle. Rebuild without `DECODER_SCAN_EN`, `mode_in`=1, `start_in` pulsed -> `busy_out` stays 0 and direct decode of `sel_in` still works.
